fpu_issue_ctrl: RTL and testbench

FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

---
 rtl/fpu_pkg.sv | 21 ++
 rtl/fpu_issue_ctrl_if.sv | 37 +++
 rtl/fpu_wdog.sv | 29 ++
 rtl/fpu_issue_ctrl.sv | 87 ++++++++
 tb/tb_fpu_issue_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared opcode constants and FSM encoding for the FP issue controller.
package fpu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_MUL = 3'b001;
    localparam logic [2:0] OP_DIV = 3'b010;
    localparam logic [2:0] OP_NEG = 3'b011;
    localparam logic [2:0] OP_MV  = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } fsm_state_t;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_MV;
    endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Issue, FPU and writeback signals of the FP issue controller.
interface fpu_issue_ctrl_if;

    logic        instr_valid;
    logic [2:0]  instr_op;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_addr;
    logic        stall;
    logic        fpu_start;
    logic [2:0]  fpu_op;
    logic [31:0] fpu_n1;
    logic [31:0] fpu_n2;
    logic        fpu_done;
    logic [31:0] fpu_result;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        err_illegal;
    logic        err_timeout;
    logic        err_clr;

    modport master (
        output instr_valid, instr_op, rs1_val, rs2_val, rd_addr,
        output fpu_done, fpu_result, err_clr,
        input  stall, fpu_start, fpu_op, fpu_n1, fpu_n2,
        input  wb_en, wb_addr, wb_data, err_illegal, err_timeout
    );

    modport slave (
        input  instr_valid, instr_op, rs1_val, rs2_val, rd_addr,
        input  fpu_done, fpu_result, err_clr,
        output stall, fpu_start, fpu_op, fpu_n1, fpu_n2,
        output wb_en, wb_addr, wb_data, err_illegal, err_timeout
    );

endinterface

// File: rtl/fpu_wdog.sv
// WAIT-state watchdog: counts stalled WAIT cycles, flags the one reaching TIMEOUT.
module fpu_wdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    logic [15:0] cnt;
    logic [15:0] cnt_inc;

    assign cnt_inc = cnt + 16'd1;
    // expired marks the cycle whose increment would make the count TIMEOUT
    assign expired = enable && (cnt_inc == 16'(TIMEOUT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt_inc;
        end
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issues one FP instruction at a time to the FPU and writes its result back.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input logic             clk,
    input logic             rst,
    fpu_issue_ctrl_if.slave bus
);

    fsm_state_t state;
    fsm_state_t state_nx;
    logic       legal_req;
    logic       wd_en;
    logic       wd_clr;
    logic       expired;

    assign legal_req = bus.instr_valid && op_legal(bus.instr_op);
    assign wd_en     = (state == S_WAIT) && !bus.fpu_done;
    assign wd_clr    = (state == S_ISSUE);

    fpu_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .enable  (wd_en),
        .clear   (wd_clr),
        .expired (expired)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (legal_req) state_nx = S_ISSUE;
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT: begin
                if (bus.fpu_done)  state_nx = S_WB;
                else if (expired)  state_nx = S_IDLE;
            end
            S_WB:    state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign bus.stall = (state == S_ISSUE) || (state == S_WAIT) ||
                       ((state == S_IDLE) && legal_req);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.fpu_start   <= 1'b0;
            bus.wb_en       <= 1'b0;
            bus.err_illegal <= 1'b0;
            bus.err_timeout <= 1'b0;
            bus.fpu_op      <= '0;
            bus.fpu_n1      <= '0;
            bus.fpu_n2      <= '0;
            bus.wb_addr     <= '0;
            bus.wb_data     <= '0;
        end else begin
            bus.fpu_start   <= (state_nx == S_ISSUE);
            bus.wb_en       <= (state_nx == S_WB);
            bus.err_illegal <= (state == S_IDLE) && bus.instr_valid &&
                               !op_legal(bus.instr_op);
            if ((state == S_IDLE) && legal_req) begin
                bus.fpu_op  <= bus.instr_op;
                bus.fpu_n1  <= bus.rs1_val;
                bus.fpu_n2  <= bus.rs2_val;
                bus.wb_addr <= bus.rd_addr;
            end
            if ((state == S_WAIT) && bus.fpu_done) begin
                bus.wb_data <= bus.fpu_result;
            end
            // a timeout raised this cycle beats a concurrent clear
            if ((state == S_WAIT) && expired) begin
                bus.err_timeout <= 1'b1;
            end else if (bus.err_clr) begin
                bus.err_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl with a writeback scoreboard.
module tb_fpu_issue_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fpu_issue_ctrl_if bus ();

    fpu_issue_ctrl #(.TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    wb_t wb_q[$];
    int  pass_cnt  = 0;
    int  total_cnt = 0;
    int  start_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // writeback monitor
    always @(negedge clk) begin
        if (bus.fpu_start === 1'b1) start_cnt++;
        if (bus.wb_en === 1'b1) begin
            if (wb_q.size() == 0) begin
                chk("wb_unexpected", 32'(bus.wb_en), 32'd0);
            end else begin
                wb_t e;
                e = wb_q.pop_front();
                chk("wb_addr", 32'(bus.wb_addr), 32'(e.addr));
                chk("wb_data", bus.wb_data, e.data);
                chk("wb_stall", 32'(bus.stall), 32'd0);
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        int s0;
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr_op    = op;
        bus.rs1_val     = a;
        bus.rs2_val     = b;
        bus.rd_addr     = rd;
        #1 chk("stall_accept", 32'(bus.stall), 32'd1);
        s0 = start_cnt;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        #1;
        chk("fpu_start", 32'(bus.fpu_start), 32'd1);
        chk("start_once", 32'(start_cnt - s0), 32'd1);
        chk("fpu_op", 32'(bus.fpu_op), 32'(op));
        chk("fpu_n1", bus.fpu_n1, a);
        chk("fpu_n2", bus.fpu_n2, b);
    endtask

    task automatic wait_done(input int lat, input logic [31:0] res,
                             input logic [31:0] n1, input logic [4:0] rd);
        wb_t e;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.rs1_val  = 32'hDEADBEEF;
                bus.rs2_val  = 32'hDEADBEEF;
                bus.instr_op = 3'b111;
                chk("start_low", 32'(bus.fpu_start), 32'd0);
            end
            chk("stall_wait", 32'(bus.stall), 32'd1);
            chk("n1_hold", bus.fpu_n1, n1);
            if (k == lat) begin
                e.addr = rd;
                e.data = res;
                wb_q.push_back(e);
                bus.fpu_result = res;
                bus.fpu_done   = 1'b1;
            end
        end
        @(negedge clk);
        bus.fpu_done   = 1'b0;
        bus.fpu_result = 32'h0;
        chk("wb_latency", 32'(bus.wb_en), 32'd1);
        @(negedge clk);
        chk("wb_one_cycle", 32'(bus.wb_en), 32'd0);
        chk("stall_idle", 32'(bus.stall), 32'd0);
    endtask

    task automatic run_timeout(input logic hold_clr);
        issue(3'b000, 32'h3F800000, 32'h3F800000, 5'd7);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 16 && hold_clr) bus.err_clr = 1'b1;
            chk("to_stall", 32'(bus.stall), 32'd1);
            chk("to_not_yet", 32'(bus.err_timeout), 32'd0);
        end
        @(negedge clk);
        bus.err_clr = 1'b0;
        chk("to_set", 32'(bus.err_timeout), 32'd1);
        chk("to_no_wb", 32'(bus.wb_en), 32'd0);
        chk("to_idle", 32'(bus.stall), 32'd0);
        @(negedge clk);
        chk("to_sticky", 32'(bus.err_timeout), 32'd1);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        chk("to_clr", 32'(bus.err_timeout), 32'd0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_start", 32'(bus.fpu_start), 32'd0);
        chk("rst_wb_en", 32'(bus.wb_en), 32'd0);
        chk("rst_ill", 32'(bus.err_illegal), 32'd0);
        chk("rst_to", 32'(bus.err_timeout), 32'd0);
        chk("rst_op", 32'(bus.fpu_op), 32'd0);
        chk("rst_n1", bus.fpu_n1, 32'd0);
        chk("rst_n2", bus.fpu_n2, 32'd0);
        chk("rst_wb_addr", 32'(bus.wb_addr), 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s0;
        bus.instr_valid = 1'b0;
        bus.instr_op    = 3'b000;
        bus.rs1_val     = 32'h0;
        bus.rs2_val     = 32'h0;
        bus.rd_addr     = 5'd0;
        bus.fpu_done    = 1'b0;
        bus.fpu_result  = 32'h0;
        bus.err_clr     = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs();
        rst = 1'b1;

        // done outside WAIT is ignored
        @(negedge clk);
        bus.fpu_done   = 1'b1;
        bus.fpu_result = 32'h11111111;
        @(negedge clk);
        bus.fpu_done = 1'b0;
        chk("stray_done_wb", 32'(bus.wb_en), 32'd0);
        chk("stray_done_stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        chk("stray_done_wb2", 32'(bus.wb_en), 32'd0);

        issue(3'b000, 32'h3F800000, 32'h40000000, 5'd5);
        wait_done(6, 32'h40400000, 32'h3F800000, 5'd5);

        issue(3'b011, 32'h3F800000, 32'h0, 5'd9);
        wait_done(3, 32'hBF800000, 32'h3F800000, 5'd9);

        issue(3'b001, 32'h40000000, 32'h40400000, 5'd12);
        wait_done(4, 32'h40C00000, 32'h40000000, 5'd12);

        // illegal opcode
        s0 = start_cnt;
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr_op    = 3'b101;
        #1 chk("ill_stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        chk("ill_pulse", 32'(bus.err_illegal), 32'd1);
        chk("ill_stall2", 32'(bus.stall), 32'd0);
        @(negedge clk);
        chk("ill_pulse_end", 32'(bus.err_illegal), 32'd0);
        @(negedge clk);
        chk("ill_no_start", 32'(start_cnt - s0), 32'd0);

        run_timeout(1'b0);
        run_timeout(1'b1);

        // done on the last allowed WAIT cycle wins
        issue(3'b100, 32'h12345678, 32'h0, 5'd20);
        wait_done(16, 32'h12345678, 32'h12345678, 5'd20);
        chk("late_done_no_err", 32'(bus.err_timeout), 32'd0);

        // reset during WAIT
        issue(3'b010, 32'h40C00000, 32'h40000000, 5'd3);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1 chk_reset_outputs();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", 32'(bus.stall), 32'd0);
        issue(3'b000, 32'h40000000, 32'h40000000, 5'd31);
        wait_done(2, 32'h40800000, 32'h40000000, 5'd31);

        repeat (3) @(negedge clk);
        chk("wb_queue_empty", 32'(wb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
